// File: rtl/gcd_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : gcd_pkg                                                |
// | Brief   : Shared constants, register map and FSM states for the  |
// |           Wishbone-mapped binary GCD engine.                     |
// | Rev     : 1.0                                                    |
// +------------------------------------------------------------------+
package gcd_pkg;

    // Word index within the 32-byte window (byte offset >> 2)
    localparam logic [2:0] c_REG_CTRL   = 3'd0;
    localparam logic [2:0] c_REG_STATUS = 3'd1;
    localparam logic [2:0] c_REG_OPA    = 3'd2;
    localparam logic [2:0] c_REG_OPB    = 3'd3;
    localparam logic [2:0] c_REG_RESULT = 3'd4;
    localparam logic [2:0] c_REG_CYCLES = 3'd5;

    localparam int c_CTRL_START  = 0;
    localparam int c_CTRL_IRQ_EN = 1;
    localparam int c_CTRL_ABORT  = 2;

    localparam int c_STAT_BUSY = 0;
    localparam int c_STAT_DONE = 1;
    localparam int c_STAT_ERR  = 2;

    localparam logic [31:0] c_CYCLES_SAT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_TWOS = 3'd2,
        S_ODDA = 3'd3,
        S_LOOP = 3'd4,
        S_FIN  = 3'd5
    } gcd_state_t;

    function automatic logic [31:0] apply_byte_sel(input logic [31:0] old_val,
                                                   input logic [31:0] new_val,
                                                   input logic [3:0]  sel);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gcd_stein_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : gcd_stein_core                                         |
// | Brief   : Binary (Stein) GCD FSM and datapath, one step a cycle, |
// |           with saturating cycle counter and abort.               |
// | Rev     : 1.0                                                    |
// +------------------------------------------------------------------+
module gcd_stein_core
    import gcd_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done_pulse,
    output logic [WIDTH-1:0] o_result,
    output logic [31:0]      o_cycles
);

    localparam int c_KW = $clog2(WIDTH + 1);

    gcd_state_t       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, w_a_nxt;
    logic [WIDTH-1:0] r_b, w_b_nxt;
    logic [WIDTH-1:0] r_res, w_res_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic [c_KW-1:0]  r_k, w_k_nxt;
    logic [31:0]      r_cycles, w_cycles_nxt;
    logic             w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_result <= '0;
            r_k      <= '0;
            r_cycles <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_res    <= w_res_nxt;
            r_result <= w_result_nxt;
            r_k      <= w_k_nxt;
            r_cycles <= w_cycles_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_res_nxt    = r_res;
        w_result_nxt = r_result;
        w_k_nxt      = r_k;
        w_cycles_nxt = r_cycles;
        w_done       = 1'b0;

        if (r_state != S_IDLE && r_cycles != c_CYCLES_SAT) begin
            w_cycles_nxt = r_cycles + 32'd1;
        end

        case (r_state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    w_a_nxt      = i_a;
                    w_b_nxt      = i_b;
                    w_k_nxt      = '0;
                    w_cycles_nxt = '0;
                    w_state_nxt  = S_INIT;
                end
            end
            S_INIT: begin
                if (r_a == '0) begin
                    w_res_nxt   = r_b;
                    w_state_nxt = S_FIN;
                end else if (r_b == '0) begin
                    w_res_nxt   = r_a;
                    w_state_nxt = S_FIN;
                end else begin
                    w_state_nxt = S_TWOS;
                end
            end
            S_TWOS: begin
                if (!(r_a[0] | r_b[0])) begin
                    w_a_nxt = r_a >> 1;
                    w_b_nxt = r_b >> 1;
                    w_k_nxt = r_k + c_KW'(1);
                end else begin
                    w_state_nxt = S_ODDA;
                end
            end
            S_ODDA: begin
                if (!r_a[0]) begin
                    w_a_nxt = r_a >> 1;
                end else begin
                    w_state_nxt = S_LOOP;
                end
            end
            S_LOOP: begin
                // a stays odd here; b is reduced until it reaches zero
                if (r_b == '0) begin
                    w_res_nxt   = r_a << r_k;
                    w_state_nxt = S_FIN;
                end else if (!r_b[0]) begin
                    w_b_nxt = r_b >> 1;
                end else if (r_a > r_b) begin
                    w_a_nxt = r_b;
                    w_b_nxt = r_a;
                end else begin
                    w_b_nxt = r_b - r_a;
                end
            end
            S_FIN: begin
                w_result_nxt = r_res;
                w_done       = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides everything: no completion, result and counter frozen
        if (i_abort && r_state != S_IDLE) begin
            w_state_nxt  = S_IDLE;
            w_cycles_nxt = r_cycles;
            w_result_nxt = r_result;
            w_done       = 1'b0;
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_done_pulse = w_done;
    assign o_result     = r_result;
    assign o_cycles     = r_cycles;

endmodule
`default_nettype wire

// File: rtl/wb_gcd_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : wb_gcd_engine                                          |
// | Brief   : Wishbone slave wrapping the Stein GCD core: decode,    |
// |           register file, sticky status bits and interrupt.       |
// | Rev     : 1.0                                                    |
// +------------------------------------------------------------------+
module wb_gcd_engine
    import gcd_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o
);

    logic             r_ack;
    logic [31:0]      r_dat;
    logic             r_irq_en;
    logic             r_done;
    logic             r_err;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;

    logic             w_hit, w_valid, w_req, w_wr, w_rd;
    logic [2:0]       w_reg;
    logic             w_ctrl_wr, w_stat_wr, w_start, w_abort;
    logic             w_start_ok, w_start_err;
    logic             w_busy, w_core_done;
    logic [WIDTH-1:0] w_result;
    logic [31:0]      w_cycles;
    logic [31:0]      w_rdata;
    logic             w_unused_adr;

    assign w_hit   = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign w_valid = wbs_cyc_i & wbs_stb_i & w_hit;
    // A request is acted on once; the ack cycle itself never re-triggers it
    assign w_req   = w_valid & ~r_ack;
    assign w_wr    = w_req & wbs_we_i;
    assign w_rd    = w_req & ~wbs_we_i;
    assign w_reg   = wbs_adr_i[4:2];
    assign w_unused_adr = ^wbs_adr_i[1:0];

    assign w_ctrl_wr   = w_wr && (w_reg == c_REG_CTRL) && wbs_sel_i[0];
    assign w_stat_wr   = w_wr && (w_reg == c_REG_STATUS) && wbs_sel_i[0];
    assign w_start     = w_ctrl_wr & wbs_dat_i[c_CTRL_START];
    assign w_abort     = w_ctrl_wr & wbs_dat_i[c_CTRL_ABORT];
    assign w_start_ok  = w_start & ~w_abort & ~w_busy;
    assign w_start_err = w_start & ~w_abort & w_busy;

    gcd_stein_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk          (wb_clk_i),
        .rst          (wb_rst_i),
        .i_start      (w_start),
        .i_abort      (w_abort),
        .i_a          (r_opa),
        .i_b          (r_opb),
        .o_busy       (w_busy),
        .o_done_pulse (w_core_done),
        .o_result     (w_result),
        .o_cycles     (w_cycles)
    );

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            c_REG_CTRL:   w_rdata[c_CTRL_IRQ_EN] = r_irq_en;
            c_REG_STATUS: begin
                w_rdata[c_STAT_BUSY] = w_busy;
                w_rdata[c_STAT_DONE] = r_done;
                w_rdata[c_STAT_ERR]  = r_err;
            end
            c_REG_OPA:    w_rdata = 32'(r_opa);
            c_REG_OPB:    w_rdata = 32'(r_opb);
            c_REG_RESULT: w_rdata = 32'(w_result);
            c_REG_CYCLES: w_rdata = w_cycles;
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_opa    <= '0;
            r_opb    <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= w_rd ? w_rdata : '0;

            if (w_ctrl_wr) begin
                r_irq_en <= wbs_dat_i[c_CTRL_IRQ_EN];
            end
            if (w_wr && w_reg == c_REG_OPA) begin
                r_opa <= WIDTH'(apply_byte_sel(32'(r_opa), wbs_dat_i, wbs_sel_i));
            end
            if (w_wr && w_reg == c_REG_OPB) begin
                r_opb <= WIDTH'(apply_byte_sel(32'(r_opb), wbs_dat_i, wbs_sel_i));
            end

            // Set beats clear on both sticky bits
            if (w_core_done) begin
                r_done <= 1'b1;
            end else if (w_start_ok || (w_stat_wr && wbs_dat_i[c_STAT_DONE])) begin
                r_done <= 1'b0;
            end

            if (w_start_err) begin
                r_err <= 1'b1;
            end else if (w_stat_wr && wbs_dat_i[c_STAT_ERR]) begin
                r_err <= 1'b0;
            end
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign irq_o     = r_done & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_wb_gcd_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_wb_gcd_engine                                       |
// | Brief   : Directed bench for a 32-bit and an 8-bit engine sharing|
// |           one Wishbone bus at different window bases.            |
// | Rev     : 1.0                                                    |
// +------------------------------------------------------------------+
module tb_wb_gcd_engine;

    localparam logic [31:0] c_B32 = 32'h3000_0000;
    localparam logic [31:0] c_B8  = 32'h3000_0020;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] wdat = '0, adr = '0;
    logic        ack32, ack8, irq32, irq8;
    logic [31:0] dat32, dat8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_gcd_engine #(.WIDTH(32), .BASE_ADDR(c_B32)) dut32 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr),
        .wbs_ack_o(ack32), .wbs_dat_o(dat32), .irq_o(irq32));

    wb_gcd_engine #(.WIDTH(8), .BASE_ADDR(c_B8)) dut8 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr),
        .wbs_ack_o(ack8), .wbs_dat_o(dat8), .irq_o(irq8));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd, output logic acked);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        acked = 1'b0;
        rd = '0;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(posedge clk);
            #1;
            if (ack32 | ack8) begin
                acked = 1'b1;
                rd = dat32 | dat8;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
        logic [31:0] rd;
        logic acked;
        wb_cycle(a, 1'b1, d, s, rd, acked);
        if (!acked) begin
            n_cmp++; n_bad++;
            $display("FAIL write_ack @0x%08h: got 0 expected 1", a);
        end
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        logic acked;
        wb_cycle(a, 1'b0, '0, 4'hF, d, acked);
        if (!acked) begin
            n_cmp++; n_bad++;
            $display("FAIL read_ack @0x%08h: got 0 expected 1", a);
        end
    endtask

    task automatic wait_idle(input logic [31:0] base, input string name);
        logic [31:0] st;
        logic idle = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            wb_read(base + 32'h04, st);
            if (!st[0]) idle = 1'b1;
        end
        chk({name, "_finish"}, {31'd0, idle}, 32'd1);
    endtask

    typedef struct {
        string       name;
        logic [31:0] base;
        int          width;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] cyc;   // 0 = only check against the worst-case bound
    } vec_t;

    vec_t vecs[12];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, cnt;
        logic acked;

        vecs[0]  = '{"g48_18",   c_B32, 32, 32'd48,         32'd18,         32'd6,          32'd0};
        vecs[1]  = '{"g0_7",     c_B32, 32, 32'd0,          32'd7,          32'd7,          32'd2};
        vecs[2]  = '{"g0_0",     c_B32, 32, 32'd0,          32'd0,          32'd0,          32'd2};
        vecs[3]  = '{"g7_0",     c_B32, 32, 32'd7,          32'd0,          32'd7,          32'd2};
        vecs[4]  = '{"gpow2",    c_B32, 32, 32'h8000_0000,  32'h4000_0000,  32'h4000_0000,  32'd0};
        vecs[5]  = '{"gbig",     c_B32, 32, 32'hFFFF_FFFB,  32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[6]  = '{"g1071",    c_B32, 32, 32'd1071,       32'd462,        32'd21,         32'd0};
        vecs[7]  = '{"w8_255_85",c_B8,  8,  32'd255,        32'd85,         32'd85,         32'd0};
        vecs[8]  = '{"w8_0_200", c_B8,  8,  32'd0,          32'd200,        32'd200,        32'd2};
        vecs[9]  = '{"w8_12_18", c_B8,  8,  32'd12,         32'd18,         32'd6,          32'd0};
        vecs[10] = '{"w8_128_64",c_B8,  8,  32'd128,        32'd64,         32'd64,         32'd0};
        vecs[11] = '{"w8_200_0", c_B8,  8,  32'd200,        32'd0,          32'd200,        32'd2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack32", {31'd0, ack32}, 32'd0);
        chk("rst_dat32", dat32, 32'd0);
        chk("rst_irq32", {31'd0, irq32}, 32'd0);
        chk("rst_irq8", {31'd0, irq8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wb_read(c_B32 + 32'(4 * i), r);
            chk($sformatf("rst_reg%0d", i), r, 32'd0);
        end
        wb_read(c_B8 + 32'h04, r);
        chk("rst_status8", r, 32'd0);

        // Table-driven jobs
        foreach (vecs[i]) begin
            wb_write(vecs[i].base + 32'h08, vecs[i].a);
            wb_write(vecs[i].base + 32'h0C, vecs[i].b);
            wb_write(vecs[i].base + 32'h00, 32'h1);
            wait_idle(vecs[i].base, vecs[i].name);
            wb_read(vecs[i].base + 32'h10, r);
            chk({vecs[i].name, "_result"}, r, vecs[i].res);
            wb_read(vecs[i].base + 32'h04, r);
            chk({vecs[i].name, "_status"}, r, 32'h2);
            wb_read(vecs[i].base + 32'h14, cnt);
            if (vecs[i].cyc != 0) begin
                chk({vecs[i].name, "_cycles"}, cnt, vecs[i].cyc);
            end else begin
                chk({vecs[i].name, "_cycles_bound"},
                    {31'd0, (cnt > 0) && (cnt <= 32'(4 * vecs[i].width + 4))}, 32'd1);
            end
        end
        #1;
        chk("irq_off_when_disabled", {31'd0, irq8}, 32'd0);

        // Interrupt on completion, cleared by DONE W1C
        wb_write(c_B32 + 32'h08, 32'd1071);
        wb_write(c_B32 + 32'h0C, 32'd462);
        wb_write(c_B32 + 32'h00, 32'h3);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 300 && !seen; i++) begin
                @(posedge clk);
                #1;
                if (irq32) seen = 1'b1;
            end
            chk("irq_rise", {31'd0, seen}, 32'd1);
        end
        wb_read(c_B32 + 32'h04, r);
        chk("irq_status", r, 32'h2);
        wb_read(c_B32 + 32'h10, r);
        chk("irq_result", r, 32'd21);
        wb_write(c_B32 + 32'h04, 32'h2);
        chk("irq_cleared", {31'd0, irq32}, 32'd0);
        wb_read(c_B32 + 32'h00, r);
        chk("ctrl_irq_en", r, 32'h2);
        wb_write(c_B32 + 32'h00, 32'h0);

        // Illegal START while busy, operand writes during a job, abort
        wb_write(c_B32 + 32'h08, 32'hFFFF_FFFF);
        wb_write(c_B32 + 32'h0C, 32'd1);
        wb_write(c_B32 + 32'h00, 32'h1);
        wb_write(c_B32 + 32'h00, 32'h1);
        wb_write(c_B32 + 32'h08, 32'h12);
        wb_read(c_B32 + 32'h04, r);
        chk("err_busy_status", r, 32'h5);
        wait_idle(c_B32, "err_job");
        wb_read(c_B32 + 32'h10, r);
        chk("err_job_result", r, 32'd1);
        wb_read(c_B32 + 32'h04, r);
        chk("err_done_status", r, 32'h6);
        wb_write(c_B32 + 32'h04, 32'h4);
        wb_read(c_B32 + 32'h04, r);
        chk("err_w1c", r, 32'h2);

        wb_write(c_B32 + 32'h08, 32'hFFFF_FFFF);
        wb_write(c_B32 + 32'h00, 32'h1);
        wb_write(c_B32 + 32'h00, 32'h4);
        wb_read(c_B32 + 32'h04, r);
        chk("abort_status", r, 32'h0);
        wb_read(c_B32 + 32'h10, r);
        chk("abort_result", r, 32'd1);
        repeat (20) @(posedge clk);
        wb_read(c_B32 + 32'h04, r);
        chk("abort_stays_idle", r, 32'h0);

        wb_write(c_B32 + 32'h08, 32'd30);
        wb_write(c_B32 + 32'h00, 32'h5);
        wb_read(c_B32 + 32'h04, r);
        chk("start_abort_status", r, 32'h0);
        wb_read(c_B32 + 32'h10, r);
        chk("start_abort_result", r, 32'd1);

        // Byte selects and zero extension
        wb_write(c_B32 + 32'h08, 32'h1122_3344);
        wb_write(c_B32 + 32'h08, 32'hAABB_CCDD, 4'b0101);
        wb_read(c_B32 + 32'h08, r);
        chk("opa_bytesel", r, 32'h11BB_33DD);
        wb_write(c_B8 + 32'h08, 32'hFFFF_FFFF);
        wb_read(c_B8 + 32'h08, r);
        chk("w8_zero_ext", r, 32'h0000_00FF);
        wb_write(c_B8 + 32'h08, 32'h0000_00AB, 4'b1110);
        wb_read(c_B8 + 32'h08, r);
        chk("w8_bytesel", r, 32'h0000_00FF);
        wb_write(c_B32 + 32'h18, 32'hDEAD_BEEF);
        wb_read(c_B32 + 32'h18, r);
        chk("unmapped_read", r, 32'h0);

        // Reset in the middle of a job
        wb_write(c_B32 + 32'h08, 32'hFFFF_FFFF);
        wb_write(c_B32 + 32'h0C, 32'd1);
        wb_write(c_B32 + 32'h00, 32'h3);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_irq", {31'd0, irq32}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            wb_read(c_B32 + 32'(4 * i), r);
            chk($sformatf("midrst_reg%0d", i), r, 32'd0);
        end
        repeat (150) @(posedge clk);
        #1;
        chk("midrst_no_irq", {31'd0, irq32}, 32'd0);
        wb_read(c_B32 + 32'h04, r);
        chk("midrst_no_done", r, 32'h0);

        // Outside every window: no ack
        wb_cycle(32'h3000_0040, 1'b0, '0, 4'hF, r, acked);
        chk("outside_no_ack", {31'd0, acked}, 32'd0);
        wb_cycle(32'h2FFF_FFE0, 1'b1, 32'h1, 4'hF, r, acked);
        chk("below_no_ack", {31'd0, acked}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
